pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central hazard sequencer for the 5-stage core. It collects the load-use stop flag from the decode-stage forwarding unit, the E-stage branch/jump redirect, the data-memory handshake and the instruction-fetch ready. It turns them into per-stage stall/flush controls plus the PC redirect select. It also holds a pending redirect across memory wait states and keeps saturating hazard counters.

Parameters:
BOOT_CYCLES, 2, cycles after reset release during which fetch is held and F-D/D-E are flushed
TIMEOUT, 255, MEM_WAIT cycles after which mem_timeout_o sets
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
load_use_i  in  1  pc_stopFlag from forwarding (`PC_STOP_ENABLE = stall)
redirect_i  in  1  branch taken / jump resolved in E
redirect_pc_i  in  32 (`RegBus)  target PC from E
mem_req_i  in  1  M-stage load/store request
mem_ready_i  in  1  data memory response/accept
imem_ready_i  in  1  instruction word valid at F
pc_stall_o  out  1  hold PC
fd_stall_o  out  1  hold F-D register
fd_flush_o  out  1  load NOP into F-D
de_stall_o  out  1  hold D-E register
de_flush_o  out  1  load NOP into D-E
em_stall_o  out  1  hold E-M register
mw_flush_o  out  1  load bubble into M-W
pc_sel_o  out  1  PC takes pc_target_o next edge
pc_target_o  out  32  redirect target
mem_timeout_o  out  1  sticky, memory wait exceeded TIMEOUT
stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1 (excluding BOOT)
flush_cnt_o  out  CNT_W  redirects applied

Behaviour:
- Clock/reset: one clock, clk; reset rst is asynchronous, active-high. Reset forces the BOOT state, boot counter 0, pending cleared, counters 0, mem_timeout_o 0.
- Output timing: state, counters and the pending register are registered. All stall/flush/pc_sel outputs are combinational from state and inputs, zero latency.
- Reset values:
  - During reset and BOOT: pc_stall_o=1, fd_flush_o=1, de_flush_o=1. All other outputs 0, pc_target_o=0.
- States: BOOT, RUN, MEM_WAIT (encodings in core_param.v).
- BOOT:
  - Outputs as in reset.
  - Counter increments each cycle; after BOOT_CYCLES cycles go to RUN.
  - BOOT_CYCLES=0 means reset exits directly to RUN.
- RUN priority, highest first:
  1. mem_req_i & !mem_ready_i: freeze everything. pc_stall, fd_stall, de_stall, em_stall, mw_flush = 1. Next state MEM_WAIT. If redirect_i is also high, set pending and latch redirect_pc_i.
  2. redirect_i: pc_sel_o=1, pc_target_o=redirect_pc_i, fd_flush_o=1, de_flush_o=1, flush_cnt++. A simultaneous load_use_i or !imem_ready_i is ignored, because the younger instructions are squashed.
  3. load_use_i: pc_stall_o=1, fd_stall_o=1, de_flush_o=1 (one bubble).
  4. !imem_ready_i: pc_stall_o=1, fd_flush_o=1.
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - While mem_ready_i=0: full freeze as in RUN item 1. A redirect_i rising while waiting also sets pending and latches the PC; the first latch wins until cleared. The wait counter increments; when it reaches TIMEOUT, mem_timeout_o sets and stays set until rst. The state remains MEM_WAIT.
  - Release cycle, mem_ready_i=1: em_stall/mw_flush=0 and the pipeline advances.
    - If pending or redirect_i: apply the redirect (pending target preferred), pc_sel=1, fd_flush=1, de_flush=1, flush_cnt++, clear pending.
    - Else apply RUN items 3 and 4.
    - Next state RUN; wait counter cleared.
- Back-to-back: mem_req_i & !mem_ready_i in the cycle right after a release re-enters MEM_WAIT normally.
- Counters: stall_cnt increments on every non-BOOT cycle with pc_stall_o=1. Both counters saturate at all-ones and never wrap.
- mem_ready_i without mem_req_i in RUN is ignored.

Decomposition:
- Shared package: add state encodings (CTRL_BOOT/RUN/MEM_WAIT) and CTRL_STATE_BUS to core_param.v. Reuse `RegBus, `PC_STOP_ENABLE/DISABLE.
- Sub-module: sat_counter (parameterised width, inc, async rst), instantiated twice.

Test Plan:
- Reset then release, BOOT_CYCLES=2 -> pc_stall/fd_flush/de_flush=1 for exactly 2 cycles after release, then all 0, stall_cnt=0.
- load_use_i=1 for 1 cycle in RUN -> same cycle pc_stall=fd_stall=de_flush=1, next cycle all 0, stall_cnt=1.
- redirect_i=1, redirect_pc_i=0x0000_0100, load_use_i=1 together -> pc_sel=1, pc_target=0x100, fd_flush=de_flush=1, pc_stall=0, flush_cnt=1.
- mem_req_i=1, mem_ready_i=0 for 3 cycles with redirect_i=1, PC 0x200 in cycle 1, then redirect_i=0 and mem_ready_i=1 -> 3 cycles of full freeze. Release cycle shows pc_sel=1, pc_target=0x200, pending cleared.
- Hold mem_ready_i=0 for TIMEOUT+5 cycles with TIMEOUT=8 -> mem_timeout_o rises after 8 wait cycles and stays 1 after release. rst clears it.
- Assert rst asynchronously mid-MEM_WAIT with pending set -> outputs immediately take the reset values. After release there is no stale pc_sel, and both counters read 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, the packed
// stage-control bundle and the fixed control patterns it drives.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 32;

  localparam logic PC_STOP_ENABLE  = 1'b1;
  localparam logic PC_STOP_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    CTRL_BOOT     = 2'd0,
    CTRL_RUN      = 2'd1,
    CTRL_MEM_WAIT = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_stall;
    logic fd_stall;
    logic fd_flush;
    logic de_stall;
    logic de_flush;
    logic em_stall;
    logic mw_flush;
    logic pc_sel;
  } ctrl_t;

  localparam ctrl_t OUT_BOOT     = 8'b1010_1000;
  localparam ctrl_t OUT_FREEZE   = 8'b1101_0110;
  localparam ctrl_t OUT_REDIRECT = 8'b0010_1001;

  // Lowest-priority hazards: load-use bubble, then fetch not ready.
  function automatic ctrl_t hazard_ctl(input logic load_use, input logic imem_ready);
    ctrl_t c;
    c = '0;
    if (load_use == PC_STOP_ENABLE) begin
      c.pc_stall = 1'b1;
      c.fd_stall = 1'b1;
      c.de_flush = 1'b1;
    end else if (!imem_ready) begin
      c.pc_stall = 1'b1;
      c.fd_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard sequencer: turns load-use, redirect, data-memory and fetch
// status into per-stage stall/flush controls and the PC redirect select.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_i,
  input  logic             redirect_i,
  input  logic [REG_W-1:0] redirect_pc_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             imem_ready_i,
  output logic             pc_stall_o,
  output logic             fd_stall_o,
  output logic             fd_flush_o,
  output logic             de_stall_o,
  output logic             de_flush_o,
  output logic             em_stall_o,
  output logic             mw_flush_o,
  output logic             pc_sel_o,
  output logic [REG_W-1:0] pc_target_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned BW = $clog2(BOOT_CYCLES + 1) + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1) + 1;

  ctrl_state_e      state, state_nxt;
  logic [BW-1:0]    boot_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [WW-1:0]    wait_cnt_inc;
  logic             pend;
  logic [REG_W-1:0] pend_pc;
  logic             boot_last;
  logic             pend_set, pend_clr, wait_inc, wait_clr;
  logic             stall_inc, flush_inc;
  ctrl_t            ctl;
  logic [REG_W-1:0] target;

  assign boot_last    = (boot_cnt == BW'(BOOT_CYCLES - 1));
  assign wait_cnt_inc = wait_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= (BOOT_CYCLES == 0) ? CTRL_RUN : CTRL_BOOT;
      boot_cnt      <= '0;
      wait_cnt      <= '0;
      pend          <= 1'b0;
      pend_pc       <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CTRL_BOOT) begin
        boot_cnt <= boot_cnt + 1'b1;
      end
      if (pend_set) begin
        pend    <= 1'b1;
        pend_pc <= redirect_pc_i;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc && (wait_cnt != WW'(TIMEOUT))) begin
        wait_cnt <= wait_cnt_inc;
      end
      if (wait_inc && (wait_cnt_inc >= WW'(TIMEOUT))) begin
        mem_timeout_o <= 1'b1;
      end
    end
  end

  always_comb begin
    ctl       = '0;
    target    = '0;
    state_nxt = state;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    wait_inc  = 1'b0;
    wait_clr  = 1'b0;
    unique case (state)
      CTRL_BOOT: begin
        ctl = OUT_BOOT;
        if (boot_last) state_nxt = CTRL_RUN;
      end
      CTRL_RUN: begin
        if (mem_req_i && !mem_ready_i) begin
          ctl       = OUT_FREEZE;
          state_nxt = CTRL_MEM_WAIT;
          pend_set  = redirect_i;
        end else if (redirect_i) begin
          ctl    = OUT_REDIRECT;
          target = redirect_pc_i;
        end else begin
          ctl = hazard_ctl(load_use_i, imem_ready_i);
        end
      end
      CTRL_MEM_WAIT: begin
        if (!mem_ready_i) begin
          ctl      = OUT_FREEZE;
          wait_inc = 1'b1;
          pend_set = redirect_i && !pend;
        end else begin
          state_nxt = CTRL_RUN;
          wait_clr  = 1'b1;
          pend_clr  = 1'b1;
          if (pend || redirect_i) begin
            ctl    = OUT_REDIRECT;
            target = pend ? pend_pc : redirect_pc_i;
          end else begin
            ctl = hazard_ctl(load_use_i, imem_ready_i);
          end
        end
      end
      default: state_nxt = CTRL_BOOT;
    endcase
    // Reset drives the boot pattern even when BOOT_CYCLES=0 resets straight into RUN.
    if (rst) begin
      ctl    = OUT_BOOT;
      target = '0;
    end
  end

  assign pc_stall_o  = ctl.pc_stall;
  assign fd_stall_o  = ctl.fd_stall;
  assign fd_flush_o  = ctl.fd_flush;
  assign de_stall_o  = ctl.de_stall;
  assign de_flush_o  = ctl.de_flush;
  assign em_stall_o  = ctl.em_stall;
  assign mw_flush_o  = ctl.mw_flush;
  assign pc_sel_o    = ctl.pc_sel;
  assign pc_target_o = target;

  assign stall_inc = ctl.pc_stall && (state != CTRL_BOOT);
  assign flush_inc = ctl.pc_sel;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: BOOT_CYCLES=2, TIMEOUT=8, 4-bit counters.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_use, redirect, mem_req, mem_ready, imem_ready;
  logic [31:0] redirect_pc;
  logic        pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush, pc_sel;
  logic [31:0] pc_target;
  logic        mem_timeout;
  logic [3:0]  stall_cnt, flush_cnt;
  logic [7:0]  ctl;

  int tests  = 0;
  int failed = 0;

  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_BOOT   = 8'b1010_1000;
  localparam logic [7:0] C_LU     = 8'b1100_1000;
  localparam logic [7:0] C_RD     = 8'b0010_1001;
  localparam logic [7:0] C_FREEZE = 8'b1101_0110;
  localparam logic [7:0] C_IMEM   = 8'b1010_0000;

  assign ctl = {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, mw_flush, pc_sel};

  always #5 clk = ~clk;

  pipeline_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_use_i    (load_use),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .mem_req_i     (mem_req),
    .mem_ready_i   (mem_ready),
    .imem_ready_i  (imem_ready),
    .pc_stall_o    (pc_stall),
    .fd_stall_o    (fd_stall),
    .fd_flush_o    (fd_flush),
    .de_stall_o    (de_stall),
    .de_flush_o    (de_flush),
    .em_stall_o    (em_stall),
    .mw_flush_o    (mw_flush),
    .pc_sel_o      (pc_sel),
    .pc_target_o   (pc_target),
    .mem_timeout_o (mem_timeout),
    .stall_cnt_o   (stall_cnt),
    .flush_cnt_o   (flush_cnt)
  );

  task automatic idle();
    load_use = 1'b0; redirect = 1'b0; redirect_pc = '0;
    mem_req = 1'b0; mem_ready = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    #12;
    tests++; if (ctl !== C_BOOT) begin failed++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_BOOT); end
    tests++; if (pc_target !== 32'h0) begin failed++; $display("FAIL reset_target: got %h expected 0", pc_target); end
    tests++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'h0) begin failed++; $display("FAIL reset_regs: got %b expected 0", {mem_timeout, stall_cnt, flush_cnt}); end
    cyc(); rst = 1'b0; #1;
    tests++; if (ctl !== C_BOOT) begin failed++; $display("FAIL boot1_ctl: got %b expected %b", ctl, C_BOOT); end
    cyc(); #1;
    tests++; if (ctl !== C_BOOT) begin failed++; $display("FAIL boot2_ctl: got %b expected %b", ctl, C_BOOT); end
    cyc(); #1;
    tests++; if (ctl !== C_IDLE) begin failed++; $display("FAIL boot_exit_ctl: got %b expected %b", ctl, C_IDLE); end
    tests++; if (stall_cnt !== 4'd0) begin failed++; $display("FAIL boot_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    cyc(); load_use = 1'b1; #1;
    tests++; if (ctl !== C_LU) begin failed++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_LU); end
    cyc(); load_use = 1'b0; #1;
    tests++; if (ctl !== C_IDLE) begin failed++; $display("FAIL load_use_after: got %b expected %b", ctl, C_IDLE); end
    tests++; if (stall_cnt !== 4'd1) begin failed++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_redirect();
    cyc(); redirect = 1'b1; redirect_pc = 32'h0000_0100; load_use = 1'b1; #1;
    tests++; if (ctl !== C_RD) begin failed++; $display("FAIL redirect_ctl: got %b expected %b", ctl, C_RD); end
    tests++; if (pc_target !== 32'h100) begin failed++; $display("FAIL redirect_target: got %h expected 00000100", pc_target); end
    cyc(); idle(); #1;
    tests++; if (flush_cnt !== 4'd1) begin failed++; $display("FAIL redirect_cnt: got %0d expected 1", flush_cnt); end
    tests++; if (stall_cnt !== 4'd1) begin failed++; $display("FAIL redirect_stall_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_imem();
    cyc(); imem_ready = 1'b0; #1;
    tests++; if (ctl !== C_IMEM) begin failed++; $display("FAIL imem_ctl: got %b expected %b", ctl, C_IMEM); end
    cyc(); idle(); #1;
    tests++; if (stall_cnt !== 4'd2) begin failed++; $display("FAIL imem_cnt: got %0d expected 2", stall_cnt); end
  endtask

  task automatic test_mem_wait_redirect();
    cyc(); mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; #1;
    tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL mw_freeze1: got %b expected %b", ctl, C_FREEZE); end
    cyc(); redirect = 1'b0; redirect_pc = 32'h300; #1;
    tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL mw_freeze2: got %b expected %b", ctl, C_FREEZE); end
    cyc(); redirect = 1'b1; redirect_pc = 32'h400; #1;
    tests++; if ({ctl, pc_target} !== {C_FREEZE, 32'h0}) begin failed++; $display("FAIL mw_freeze3: got %b/%h expected %b/0", ctl, pc_target, C_FREEZE); end
    cyc(); redirect = 1'b0; mem_ready = 1'b1; #1;
    tests++; if (ctl !== C_RD) begin failed++; $display("FAIL mw_release_ctl: got %b expected %b", ctl, C_RD); end
    tests++; if (pc_target !== 32'h200) begin failed++; $display("FAIL mw_release_target: got %h expected 00000200", pc_target); end
    cyc(); idle(); #1;
    tests++; if (ctl !== C_IDLE) begin failed++; $display("FAIL mw_pending_clear: got %b expected %b", ctl, C_IDLE); end
    tests++; if ({stall_cnt, flush_cnt} !== {4'd5, 4'd2}) begin failed++; $display("FAIL mw_counts: got %0d/%0d expected 5/2", stall_cnt, flush_cnt); end
  endtask

  task automatic test_back_to_back();
    cyc(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL b2b_enter: got %b expected %b", ctl, C_FREEZE); end
    cyc(); #1;
    cyc(); mem_ready = 1'b1; load_use = 1'b1; #1;
    tests++; if (ctl !== C_LU) begin failed++; $display("FAIL b2b_release_lu: got %b expected %b", ctl, C_LU); end
    cyc(); mem_ready = 1'b0; load_use = 1'b0; #1;
    tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL b2b_reenter: got %b expected %b", ctl, C_FREEZE); end
    cyc(); #1;
    tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL b2b_wait: got %b expected %b", ctl, C_FREEZE); end
    cyc(); mem_ready = 1'b1; mem_req = 1'b0; #1;
    tests++; if (ctl !== C_IDLE) begin failed++; $display("FAIL b2b_release_idle: got %b expected %b", ctl, C_IDLE); end
    cyc(); idle(); #1;
    tests++; if (stall_cnt !== 4'd10) begin failed++; $display("FAIL b2b_cnt: got %0d expected 10", stall_cnt); end
  endtask

  task automatic test_timeout();
    cyc(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    tests++; if ({ctl, mem_timeout} !== {C_FREEZE, 1'b0}) begin failed++; $display("FAIL to_enter: got %b/%b expected %b/0", ctl, mem_timeout, C_FREEZE); end
    for (int i = 1; i <= 13; i++) begin
      cyc(); #1;
      if (i == 5) begin
        tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL to_freeze: got %b expected %b", ctl, C_FREEZE); end
      end
      if (i == 8) begin
        tests++; if (mem_timeout !== 1'b0) begin failed++; $display("FAIL to_before: got %b expected 0", mem_timeout); end
      end
      if (i == 9) begin
        tests++; if (mem_timeout !== 1'b1) begin failed++; $display("FAIL to_set: got %b expected 1", mem_timeout); end
      end
    end
    cyc(); mem_ready = 1'b1; mem_req = 1'b0; #1;
    tests++; if ({ctl, mem_timeout} !== {C_IDLE, 1'b1}) begin failed++; $display("FAIL to_release: got %b/%b expected %b/1", ctl, mem_timeout, C_IDLE); end
    cyc(); idle(); #1;
    tests++; if (mem_timeout !== 1'b1) begin failed++; $display("FAIL to_sticky: got %b expected 1", mem_timeout); end
    tests++; if (stall_cnt !== 4'd15) begin failed++; $display("FAIL stall_saturate: got %0d expected 15", stall_cnt); end
  endtask

  task automatic test_async_reset();
    cyc(); mem_req = 1'b1; mem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h500; #1;
    cyc(); redirect = 1'b0; #1;
    tests++; if (ctl !== C_FREEZE) begin failed++; $display("FAIL ar_wait: got %b expected %b", ctl, C_FREEZE); end
    #2 rst = 1'b1; #1;
    tests++; if ({ctl, pc_target} !== {C_BOOT, 32'h0}) begin failed++; $display("FAIL ar_outputs: got %b/%h expected %b/0", ctl, pc_target, C_BOOT); end
    tests++; if ({mem_timeout, stall_cnt, flush_cnt} !== 9'h0) begin failed++; $display("FAIL ar_regs: got %b expected 0", {mem_timeout, stall_cnt, flush_cnt}); end
    cyc(); idle(); rst = 1'b0; #1;
    tests++; if (ctl !== C_BOOT) begin failed++; $display("FAIL ar_boot1: got %b expected %b", ctl, C_BOOT); end
    cyc(); #1;
    cyc(); #1;
    tests++; if ({ctl, pc_target} !== {C_IDLE, 32'h0}) begin failed++; $display("FAIL ar_no_stale: got %b/%h expected %b/0", ctl, pc_target, C_IDLE); end
    tests++; if ({stall_cnt, flush_cnt} !== 8'h00) begin failed++; $display("FAIL ar_counts: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_imem();
    test_mem_wait_redirect();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
